// File: rtl/alu_issue.sv
//------------------------------------------------------------------------------
// Module      : alu_issue
// Description : Credit-based issue stage feeding an external registered ALU,
//               with an in-order result FIFO carrying tag and flags.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [3:0]  in_tag,
    output logic [3:0]  alu_ctrl,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [3:0]  out_tag,
    output logic        out_zero,
    output logic        out_neg,
    output logic        busy
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    logic          v1;
    logic          v2;
    logic [3:0]    tag1;
    logic [3:0]    tag2;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [15:0]   mem_data [DEPTH];
    logic [3:0]    mem_tag  [DEPTH];
    logic          mem_zero [DEPTH];
    logic          mem_neg  [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic [SW-1:0] credits_used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Every request in S1, S2 or the FIFO holds one credit, so a FIFO write can never meet a full FIFO.
    assign credits_used = SW'(count) + SW'(v1) + SW'(v2);
    assign in_ready     = resetn && (credits_used < SW'(DEPTH));
    assign accept       = in_valid && in_ready;
    assign push         = v2;
    assign out_valid    = resetn && (count != '0);
    assign pop          = out_valid && out_ready;
    assign busy         = v1 | v2 | (count != '0);

    assign out_data     = mem_data[rd_ptr];
    assign out_tag      = mem_tag[rd_ptr];
    assign out_zero     = mem_zero[rd_ptr];
    assign out_neg      = mem_neg[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            tag1     <= '0;
            tag2     <= '0;
            alu_ctrl <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            v1   <= accept;
            v2   <= v1;
            tag2 <= tag1;
            if (accept) begin
                alu_ctrl <= in_op;
                alu_a    <= in_a;
                alu_b    <= in_b;
                tag1     <= in_tag;
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= alu_y;
            mem_tag[wr_ptr]  <= tag2;
            mem_zero[wr_ptr] <= (alu_y == 16'h0000);
            mem_neg[wr_ptr]  <= alu_y[15];
        end
    end

endmodule

`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: DEPTH, default 4, result FIFO entries and total credit limit; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream request valid.
REQ-005 in_ready  output  1  request accepted when in_valid && in_ready at posedge clk.
REQ-006 in_op  input  4  ALU opcode from the shared constants package (ALU_OP_*).
REQ-007 in_a, in_b  input  16 each  operands.
REQ-008 in_tag  input  4  destination tag, returned with the result.
REQ-009 alu_ctrl  output  4  opcode to the ALU ctrl port.
REQ-010 alu_a, alu_b  output  16 each  operands to the ALU a/b ports.
REQ-011 alu_y  input  16  ALU registered result, valid one clock after alu_ctrl/alu_a/alu_b.
REQ-012 out_valid  output  1  result FIFO head valid.
REQ-013 out_ready  input  1  downstream pops head when out_valid && out_ready at posedge clk.
REQ-014 out_data  output  16  result; out_tag  output  4  tag of that result.
REQ-015 out_zero, out_neg  output  1 each  flags: out_data==0, out_data[15].
REQ-016 busy  output  1  high when any request is in flight or the FIFO is non-empty.

Function
REQ-017 Pipeline: S1 (operands registered to alu_*, v1, tag1), S2 (ALU computing, v2, tag2), FIFO write.
REQ-018 On accept at edge E0: alu_ctrl/alu_a/alu_b <= in_op/in_a/in_b, v1 <= 1, tag1 <= in_tag.
REQ-019 Each edge: v2 <= v1, tag2 <= tag1; when v2 is 1, {alu_y, tag2, alu_y==0, alu_y[15]} is written to the FIFO.
REQ-020 Latency: accept at E0 -> entry written at E2 -> out_valid high in the cycle after E2 (2 clocks), when the FIFO was empty.
REQ-021 alu_ctrl/alu_a/alu_b hold their last values when no request is accepted; v1 deasserts.
REQ-022 Credits: in_ready = (fifo_count + v1 + v2 < DEPTH); combinational from registered state only, never from in_valid or out_ready.
REQ-023 The credit rule guarantees a FIFO write never meets a full FIFO; no result is ever dropped or overwritten.
REQ-024 FIFO is first-in first-out; results leave in acceptance order; read/write pointers wrap modulo DEPTH.
REQ-025 A simultaneous write and pop in the same edge leaves fifo_count unchanged, including at count==DEPTH-1 and count==1.
REQ-026 A pop with the FIFO empty is ignored; out_data/out_tag/out_flags are don't-care while out_valid is 0.
REQ-027 out_data, out_tag, out_zero and out_neg remain stable while out_valid && !out_ready.
REQ-028 Back-to-back accepts are allowed every cycle while in_ready is 1; full throughput is 1 result/clock with out_ready held high.
REQ-029 Opcodes pass through unmodified; the block neither decodes nor rejects opcodes.
REQ-030 busy = v1 | v2 | (fifo_count != 0).

Reset
REQ-031 While resetn is 0 at posedge clk: v1, v2, FIFO pointers and fifo_count go to 0; alu_ctrl, alu_a, alu_b, tag1 and tag2 go to 0.
REQ-032 While resetn is 0: out_valid is 0, in_ready is 0, and busy is 0 after the first reset edge.
REQ-033 Reset during operation discards all in-flight and buffered results; no stale result appears after reset is released.
REQ-034 The first accept is possible at the first edge with resetn is 1.

Verification
REQ-035 Single ADD: a=0x0003, b=0x0004, tag=5, out_ready=1 -> out_valid 2 clocks after accept; out_data=0x0007, tag=5, zero=0, neg=0.
REQ-036 Flags: SUB a=0x4000, b=0x4000 -> 0x0000, zero=1; SUB a=0x0003, b=0x0004 -> 0xFFFF, neg=1, zero=0.
REQ-037 Backpressure: out_ready=0, stream of 6 ADDs with tags 0..5 and DEPTH=4.
  - in_ready drops after 4 accepts; busy stays 1.
  - Raise out_ready -> tags 0..5 appear in order, each result correct; in_ready reasserts.
REQ-038 Throughput: out_ready=1, 16 consecutive XORs -> 16 results on 16 consecutive cycles.
  - Order preserved; pointer wrap is exercised.
REQ-039 Simultaneous push/pop: hold fifo_count at DEPTH-1, then pop and write in the same edge.
  - Count unchanged; no loss, no duplicate.
REQ-040 Mid-op reset: 3 requests in flight/buffered, resetn=0 for 1 clock.
  - out_valid=0 and busy=0 after that edge; the next ADD 0x8000+0x0001 returns only 0x8001.
